wide_add_sequencer: RTL and testbench
=====================================

// Module: wide_add_sequencer
// PURPOSE
//  Multi-cycle WIDTH-bit adder controller for the MAC datapath: performs sum = x + y + cin
//  by sequencing one CHUNK-bit ripple-carry slice over NCHUNK = WIDTH/CHUNK cycles, LSB chunk
//  first, with the inter-chunk carry held in a register. Trades the full-width ripple path for
//  a short critical path. Sits between the MAC accumulator and its operand/result buffers.
// PARAMETERS
//  WIDTH  512  operand/result width in bits; WIDTH % CHUNK == 0 is required (elaboration error otherwise)
//  CHUNK  64   adder slice width in bits; CHUNK == WIDTH is legal (NCHUNK = 1)
//  (localparam NCHUNK = WIDTH/CHUNK; CW = max(1, $clog2(NCHUNK)) for the chunk counter)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands x, y, cin valid
//  in_ready   out  1      block accepts operands; high only in IDLE
//  x          in   WIDTH  addend
//  y          in   WIDTH  addend
//  cin        in   1      carry in to bit 0
//  out_valid  out  1      sum/cout valid; held until out_ready
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  registered result, (x + y + cin) mod 2^WIDTH
//  cout       out  1      carry out of bit WIDTH-1
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, busy=0,
//    sum=0, cout=0, chunk counter=0, carry reg=0, operand regs=0.
//  - FSM states IDLE, RUN, DONE:
//    IDLE: in_valid&&in_ready -> capture x, y into operand regs, carry reg<=cin, cnt<=0, go RUN.
//    RUN : each cycle add operand chunk cnt (bits cnt*CHUNK +: CHUNK) plus carry reg; write
//          result into sum chunk cnt; carry reg<=slice carry; cnt<=cnt+1.
//          When cnt==NCHUNK-1: cout<=slice carry, go DONE (out_valid=1 next cycle).
//    DONE: out_valid=1; out_valid&&out_ready -> IDLE (in_ready=1 next cycle).
//  - Latency: out_valid rises exactly NCHUNK cycles after the accepting edge (8 at defaults);
//    min issue interval NCHUNK+2 cycles with out_ready tied high.
//  - Operands are sampled only at the accepting edge; x/y/cin/in_valid changes afterwards
//    are ignored. in_valid while busy is ignored (no queueing, no error).
//  - sum/cout stable from out_valid rise until the handshake edge, and after it until the
//    next operation overwrites them chunk by chunk. sum chunks not yet written in RUN hold
//    the previous result; only DONE contents are defined.
//  - Carry is never dropped between chunks; the final chunk carry is cout; no carry wraps
//    back to bit 0.
//  - NCHUNK==1: a single RUN cycle, counter stays 0.
//  - rst_n asserted mid RUN/DONE: operation aborted, all outputs return to reset values
//    immediately; no partial result is ever presented with out_valid.
//  - in_ready is a function of state only (no combinational path from out_ready).
// STRUCTURE
//  - Shared package mac_pkg: state encoding constants (IDLE/RUN/DONE), default WIDTH/CHUNK.
//  - One sub-module: chunk_adder #(CHUNK) (a, b, cin -> s, cout), combinational ripple-carry
//    slice built from the existing full-adder cell; instantiated once.
//  - Operand regs may be right-shift registers (shift by CHUNK per RUN cycle) instead of
//    indexed muxes; result ordering is unchanged either way.
// TESTING
//  1 Reset: hold rst_n=0 with in_valid=1 -> in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
//  2 x=all ones, y=1, cin=0 -> after 8 cycles sum=0, cout=1 (carry crosses all 8 chunks).
//  3 x=2^64-1, y=1, cin=0 -> sum=2^64 (bit 64 set only), cout=0; x=0, y=0, cin=1 -> sum=1.
//  4 Backpressure: out_ready=0 for 5 cycles after out_valid, in_valid=1 with new operands
//    -> out_valid, sum, cout stable, in_ready=0, new operands not taken; release -> IDLE.
//  5 Reset pulse during RUN at cnt=3 -> outputs to reset values at once; next op
//    (x=5, y=7, cin=1) -> sum=13, cout=0.
//  6 1000 random back-to-back ops, random out_ready, vs golden x+y+cin; repeat with
//    CHUNK=512 -> latency 1, and CHUNK=128 -> latency 4.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath blocks.
//  - state_t   : controller state encoding (IDLE / RUN / DONE)
//  - DEF_WIDTH : default operand width
//  - DEF_CHUNK : default adder slice width
//  - cnt_w()   : counter width for n steps, never less than 1 bit
//  - fa()      : single-bit full-adder cell, returns {carry, sum}
package mac_pkg;

  localparam int DEF_WIDTH = 512;
  localparam int DEF_CHUNK = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [1:0] fa(input logic a, input logic b, input logic ci);
    return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/wide_add_sequencer_chunk_adder.sv
// chunk_adder: combinational CHUNK-bit ripple-carry slice.
// Ports:
//  a, b  in   CHUNK  addends
//  cin   in   1      carry into bit 0
//  s     out  CHUNK  a + b + cin (low CHUNK bits)
//  cout  out  1      carry out of bit CHUNK-1
// The carry is threaded through a scalar loop variable, so the chain is a
// straight ripple of full-adder cells with no feedback through a vector.
module chunk_adder
  import mac_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic c;

  always_comb begin
    c = cin;
    s = '0;
    for (int i = 0; i < CHUNK; i++) begin
      {c, s[i]} = fa(a[i], b[i], c);
    end
    cout = c;
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: multi-cycle WIDTH-bit adder, sum = x + y + cin.
// One CHUNK-bit ripple slice is reused for NCHUNK = WIDTH/CHUNK cycles,
// LSB chunk first, with the inter-chunk carry kept in a register.
// Ports:
//  clk, rst_n          clock (rising) / async active-low reset
//  in_valid, in_ready  operand handshake; in_ready high only in IDLE
//  x, y, cin           operands, sampled only on the accepting edge
//  out_valid,out_ready result handshake; out_valid held until accepted
//  sum, cout           registered result and final carry
//  busy                high while an operation is in RUN or DONE
module wide_add_sequencer
  import mac_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_w(NCHUNK);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("wide_add_sequencer: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           st;
  logic [WIDTH-1:0] xr, yr;   // operands, shifted right one chunk per RUN cycle
  logic [WIDTH-1:0] xn, yn;
  logic             cr;       // carry between chunks
  logic [CW-1:0]    cnt;
  logic             last;
  logic [CHUNK-1:0] s_sl;
  logic             c_sl;

  // The active chunk always sits in the low bits of the operand registers.
  chunk_adder #(.CHUNK(CHUNK)) u_add (
    .a    (xr[CHUNK-1:0]),
    .b    (yr[CHUNK-1:0]),
    .cin  (cr),
    .s    (s_sl),
    .cout (c_sl)
  );

  if (NCHUNK > 1) begin : g_shr
    assign xn = {{CHUNK{1'b0}}, xr[WIDTH-1:CHUNK]};
    assign yn = {{CHUNK{1'b0}}, yr[WIDTH-1:CHUNK]};
  end else begin : g_shr1
    assign xn = '0;
    assign yn = '0;
  end

  assign last = (cnt == CW'(NCHUNK - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      cnt       <= '0;
      cr        <= 1'b0;
      xr        <= '0;
      yr        <= '0;
    end else begin
      case (st)
        ST_IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone accepts.
          if (in_valid) begin
            xr       <= x;
            yr       <= y;
            cr       <= cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            st       <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NCHUNK; i++) begin
            if (cnt == CW'(i)) sum[i*CHUNK +: CHUNK] <= s_sl;
          end
          cr <= c_sl;
          xr <= xn;
          yr <= yn;
          if (last) begin
            cnt       <= '0;
            cout      <= c_sl;
            out_valid <= 1'b1;
            st        <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            st        <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          st        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer.
// Directed tests on a CHUNK=64 instance, then concurrent random traffic on
// CHUNK=64, 512 and 128 instances, each with its own expected-result queue.
module tb_wide_add_sequencer;

  localparam int W    = 512;
  localparam int NOPS = 1000;

  logic         clk, rst_n;
  logic         in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [W-1:0] x, y, sum;

  int errs = 0, checks = 0, cyc = 0;
  bit rstart = 0;

  logic [W:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wide_add_sequencer #(.WIDTH(W), .CHUNK(64)) u_dut (
    .clk, .rst_n, .in_valid, .in_ready, .x, .y, .cin,
    .out_valid, .out_ready, .sum, .cout, .busy
  );

  task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] v;
    for (int i = 0; i < W/32; i++) v[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 7))
      0: v = '1;
      1: v = '0;
      default: ;
    endcase
    return v;
  endfunction

  // One directed operation. hold>0 applies backpressure for that many cycles
  // after out_valid while offering new operands that must be ignored.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input int hold);
    int n;
    logic [W:0] e;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk({tag, "_rdy"}, W'(in_ready), 1);
    out_ready = (hold == 0);
    x = a; y = b; cin = c; in_valid = 1'b1;
    exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
    @(negedge clk);
    in_valid = 1'b0;
    x = ~a; cin = ~c;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk({tag, "_lat"}, (W+1)'(n), 8);
    e = exp_q.pop_front();
    chk({tag, "_sum"}, {1'b0, sum}, {1'b0, e[W-1:0]});
    chk({tag, "_cout"}, (W+1)'(cout), (W+1)'(e[W]));
    if (hold > 0) begin
      x = rnd_w(); y = rnd_w(); cin = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({tag, "_bp_ov"}, (W+1)'(out_valid), 1);
        chk({tag, "_bp_sum"}, {1'b0, sum}, {1'b0, e[W-1:0]});
        chk({tag, "_bp_cout"}, (W+1)'(cout), (W+1)'(e[W]));
        chk({tag, "_bp_rdy"}, (W+1)'(in_ready), 0);
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_ov_lo"}, (W+1)'(out_valid), 0);
    chk({tag, "_idle_rdy"}, (W+1)'(in_ready), 1);
    chk({tag, "_idle_busy"}, (W+1)'(busy), 0);
  endtask

  // Random traffic per chunk configuration.
  for (genvar k = 0; k < 3; k++) begin : g_rnd
    localparam int CK = (k == 0) ? 64 : (k == 1) ? 512 : 128;
    localparam int NC = W / CK;
    logic         iv, ir, ov, ordy, ci, co, bz;
    logic [W-1:0] xa, ya, s;
    bit           fin = 0;

    wide_add_sequencer #(.WIDTH(W), .CHUNK(CK)) u_r (
      .clk, .rst_n, .in_valid(iv), .in_ready(ir), .x(xa), .y(ya), .cin(ci),
      .out_valid(ov), .out_ready(ordy), .sum(s), .cout(co), .busy(bz)
    );

    initial begin
      logic [W:0] q[$];
      logic [W:0] e;
      int   acc, done, budget;
      logic ov_d;
      iv = 1'b0; ordy = 1'b1; ci = 1'b0; xa = '0; ya = '0;
      acc = 0; done = 0; budget = 0; ov_d = 1'b0;
      wait (rstart);
      while (done < NOPS && budget < 60000) begin
        @(negedge clk);
        budget++;
        if (ov && !ov_d) chk($sformatf("rnd%0d_lat", CK), (W+1)'(cyc - acc), (W+1)'(NC));
        ov_d = ov;
        ordy = ($urandom_range(0, 3) != 0);
        if (ov && ordy) begin
          if (q.size() == 0) chk($sformatf("rnd%0d_q", CK), 1, 0);
          else begin
            e = q.pop_front();
            chk($sformatf("rnd%0d_sum", CK), {1'b0, s}, {1'b0, e[W-1:0]});
            chk($sformatf("rnd%0d_cout", CK), (W+1)'(co), (W+1)'(e[W]));
          end
          done++;
        end
        iv = ($urandom_range(0, 3) != 0);
        xa = rnd_w(); ya = rnd_w(); ci = 1'($urandom);
        if (iv && ir) begin
          q.push_back({1'b0, xa} + {1'b0, ya} + {{W{1'b0}}, ci});
          acc = cyc + 1;
        end
      end
      chk($sformatf("rnd%0d_done", CK), (W+1)'(done), (W+1)'(NOPS));
      iv = 1'b0;
      fin = 1'b1;
    end
  end

  initial begin
    logic [W-1:0] ones, v;
    int n;
    ones = '1;
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    x = ones; y = ones; cin = 1'b1;

    // Reset with in_valid asserted.
    repeat (3) @(negedge clk);
    chk("rst_rdy",  (W+1)'(in_ready), 1);
    chk("rst_ov",   (W+1)'(out_valid), 0);
    chk("rst_busy", (W+1)'(busy), 0);
    chk("rst_sum",  {1'b0, sum}, 0);
    chk("rst_cout", (W+1)'(cout), 0);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Carry through every chunk.
    run_op("allones", ones, 1, 1'b0, 0);
    chk("allones_zero", {cout, sum}, {1'b1, {W{1'b0}}});
    // Carry across one chunk boundary, and cin alone.
    v = '0; v[63:0] = '1;
    run_op("bnd64", v, 1, 1'b0, 0);
    v = '0; v[64] = 1'b1;
    chk("bnd64_bit", {cout, sum}, {1'b0, v});
    run_op("cin", 0, 0, 1'b1, 0);
    chk("cin_one", {cout, sum}, 1);

    // Backpressure.
    run_op("bp", 3, 4, 1'b0, 5);

    // Reset pulse mid-RUN, counter at 3.
    @(negedge clk);
    x = ones; y = ones; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", (W+1)'(busy), 1);
    chk("mid_ov",   (W+1)'(out_valid), 0);
    rst_n = 1'b0;
    #1;
    chk("ab_rdy",  (W+1)'(in_ready), 1);
    chk("ab_ov",   (W+1)'(out_valid), 0);
    chk("ab_busy", (W+1)'(busy), 0);
    chk("ab_sum",  {1'b0, sum}, 0);
    chk("ab_cout", (W+1)'(cout), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 5, 7, 1'b1, 0);
    chk("post_rst_13", {cout, sum}, 13);

    // Random traffic on all three chunk sizes.
    rstart = 1'b1;
    n = 0;
    while (!(g_rnd[0].fin && g_rnd[1].fin && g_rnd[2].fin) && n < 70000) begin
      @(negedge clk);
      n++;
    end
    chk("rnd_all_fin", (W+1)'(g_rnd[0].fin && g_rnd[1].fin && g_rnd[2].fin), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
